// File: rtl/ex_iter_divider_pkg.sv
// Shared definitions for the execute-stage iterative divider: ALU function codes,
// FSM state encoding and the fixed special-case result constants.
package ex_iter_divider_pkg;

    localparam logic [4:0] ALU_DIV  = 5'd12;
    localparam logic [4:0] ALU_DIVU = 5'd13;
    localparam logic [4:0] ALU_REM  = 5'd14;
    localparam logic [4:0] ALU_REMU = 5'd15;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    function automatic logic is_div_op(input logic [4:0] fn);
        return (fn == ALU_DIV) || (fn == ALU_DIVU) || (fn == ALU_REM) || (fn == ALU_REMU);
    endfunction

endpackage

// File: rtl/ex_iter_divider_core.sv
// Radix-2 restoring unsigned divider datapath: one quotient bit per step, MSB first.
// Exposes the post-step quotient/remainder so the wrapper can capture the final values.
module div_unsigned_core #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            last,
    output logic [XLEN-1:0] quo_next,
    output logic [XLEN-1:0] rem_next
);

    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  div_q;
    logic [CNT_W-1:0] cnt;
    logic [XLEN:0]    r_shift;
    logic             ge;

    // The shifted partial remainder needs one extra bit; after a restoring step it always fits XLEN.
    always_comb begin
        r_shift  = {rem_q, quo_q[XLEN-1]};
        ge       = (r_shift >= {1'b0, div_q});
        rem_next = ge ? (r_shift[XLEN-1:0] - div_q) : r_shift[XLEN-1:0];
        quo_next = {quo_q[XLEN-2:0], ge};
        last     = (cnt == CNT_W'(XLEN - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            div_q <= divisor;
        end else if (step) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
        end
    end

endmodule

// File: rtl/ex_iter_divider.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit: FSM, sign handling and special cases
// around the unsigned shift/subtract core.
module ex_iter_divider
    import ex_iter_divider_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [4:0]      alu_function,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    div_state_t      state, state_next;
    logic            accept, special, is_signed, is_rem;
    logic            load, step, last;
    logic [XLEN-1:0] abs1, abs2, special_val;
    logic [XLEN-1:0] quo_next, rem_next;
    logic            op_rem, neg_q, neg_r;
    logic [XLEN-1:0] pend;
    logic [XLEN-1:0] result_q;

    function automatic logic [XLEN-1:0] abs_val(input logic signed [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? XLEN'(-v) : v;
    endfunction

    function automatic logic [XLEN-1:0] apply_sign(input logic signed [XLEN-1:0] v, input logic neg);
        return neg ? XLEN'(-v) : v;
    endfunction

    always_comb begin
        is_signed   = (alu_function == ALU_DIV) || (alu_function == ALU_REM);
        is_rem      = (alu_function == ALU_REM) || (alu_function == ALU_REMU);
        abs1        = abs_val(in1, is_signed);
        abs2        = abs_val(in2, is_signed);
        special     = 1'b0;
        special_val = '0;
        if (in2 == '0) begin
            special     = 1'b1;
            special_val = is_rem ? in1 : DIV_BY_ZERO_Q;
        end else if (is_signed && (in1 == INT_MIN) && (in2 == '1)) begin
            special     = 1'b1;
            special_val = is_rem ? '0 : INT_MIN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !kill && is_div_op(alu_function)) begin
                    accept     = 1'b1;
                    load       = !special;
                    state_next = special ? DONE : CALC;
                end
            end
            CALC: begin
                if (kill) begin
                    state_next = IDLE;
                end else begin
                    step = 1'b1;
                    if (last) state_next = DONE;
                end
            end
            DONE: begin
                done       = !kill;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    div_unsigned_core #(.XLEN(XLEN), .CNT_W(CNT_W)) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .step     (step),
        .dividend (abs1),
        .divisor  (abs2),
        .last     (last),
        .quo_next (quo_next),
        .rem_next (rem_next)
    );

    // The pending value only becomes the held result once done actually fires, so a kill keeps the old one.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_rem <= is_rem;
            neg_q  <= is_signed && (in1[XLEN-1] ^ in2[XLEN-1]);
            neg_r  <= is_signed && in1[XLEN-1];
            if (special) pend <= special_val;
        end else if (step && last) begin
            pend <= op_rem ? apply_sign(rem_next, neg_r) : apply_sign(quo_next, neg_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)     result_q <= '0;
        else if (done) result_q <= pend;
    end

    assign result = (state == DONE) ? pend : result_q;

endmodule

// File: tb/tb_ex_iter_divider.sv
// Directed-vector bench for ex_iter_divider: latency, signed/unsigned results,
// special cases, kill, reset mid-operation and start-while-busy handling.
module tb_ex_iter_divider;
    import ex_iter_divider_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [4:0]  alu_function;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        kill;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    ex_iter_divider dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .alu_function (alu_function),
        .in1          (in1),
        .in2          (in2),
        .kill         (kill),
        .busy         (busy),
        .done         (done),
        .result       (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Issues one request and returns the result plus the number of edges from request to done (-1 on timeout).
    task automatic do_op(input logic [4:0] fn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output logic busy1);
        @(negedge clk);
        alu_function = fn; in1 = a; in2 = b; start = 1'b1;
        lat = -1; res = 32'h0; busy1 = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0;
                busy1 = busy;
            end
            if (done) begin
                res = result;
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; kill = 1'b0;
        alu_function = 5'd0; in1 = 32'h0; in2 = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL reset_state busy=%b done=%b result=%h want 0 0 0", busy, done, result);
        end
        reset = 1'b0;
    endtask

    task automatic test_unsigned;
        logic [31:0] r;
        int          lat;
        logic        b1;
        do_op(ALU_DIVU, 32'd100, 32'd7, r, lat, b1);
        checks++;
        if (b1 !== 1'b1) begin errors++; $display("FAIL divu_busy got %b want 1", b1); end
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL divu_latency got %0d want 33", lat); end
        checks++;
        if (r !== 32'd14) begin errors++; $display("FAIL divu_100_7 got %h want %h", r, 32'd14); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL done_pulse_width done=%b busy=%b want 0 0", done, busy);
        end
        checks++;
        if (result !== 32'd14) begin errors++; $display("FAIL result_hold got %h want %h", result, 32'd14); end
        do_op(ALU_REMU, 32'd100, 32'd7, r, lat, b1);
        checks++;
        if (r !== 32'd2 || lat !== 33) begin
            errors++; $display("FAIL remu_100_7 got %h lat %0d want 2 lat 33", r, lat);
        end
    endtask

    task automatic test_signed;
        logic [31:0] r;
        int          lat;
        logic        b1;
        do_op(ALU_DIV, 32'hFFFF_FFF9, 32'd2, r, lat, b1);
        checks++;
        if (r !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_m7_2 got %h want fffffffd", r); end
        do_op(ALU_REM, 32'hFFFF_FFF9, 32'd2, r, lat, b1);
        checks++;
        if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_m7_2 got %h want ffffffff", r); end
        do_op(ALU_REM, 32'd7, 32'hFFFF_FFFE, r, lat, b1);
        checks++;
        if (r !== 32'd1) begin errors++; $display("FAIL rem_7_m2 got %h want 00000001", r); end
        do_op(ALU_DIV, 32'd7, 32'hFFFF_FFFE, r, lat, b1);
        checks++;
        if (r !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_7_m2 got %h want fffffffd", r); end
    endtask

    task automatic test_special;
        logic [31:0] r;
        int          lat;
        logic        b1;
        do_op(ALU_DIV, 32'd5, 32'd0, r, lat, b1);
        checks++;
        if (r !== 32'hFFFF_FFFF || lat !== 1) begin
            errors++; $display("FAIL div_by_zero got %h lat %0d want ffffffff lat 1", r, lat);
        end
        do_op(ALU_REMU, 32'd5, 32'd0, r, lat, b1);
        checks++;
        if (r !== 32'd5 || lat !== 1) begin
            errors++; $display("FAIL remu_by_zero got %h lat %0d want 00000005 lat 1", r, lat);
        end
        do_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, b1);
        checks++;
        if (r !== 32'h8000_0000 || lat !== 1) begin
            errors++; $display("FAIL div_overflow got %h lat %0d want 80000000 lat 1", r, lat);
        end
        do_op(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, b1);
        checks++;
        if (r !== 32'h0 || lat !== 1) begin
            errors++; $display("FAIL rem_overflow got %h lat %0d want 00000000 lat 1", r, lat);
        end
        do_op(ALU_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, b1);
        checks++;
        if (r !== 32'h0 || lat !== 33) begin
            errors++; $display("FAIL divu_no_overflow got %h lat %0d want 00000000 lat 33", r, lat);
        end
    endtask

    task automatic test_ignored_starts;
        @(negedge clk);
        alu_function = 5'd0; in1 = 32'd9; in2 = 32'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL non_div_start busy got %b want 0", busy); end
        alu_function = ALU_DIVU; kill = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL kill_start_idle busy got %b want 0", busy); end
        start = 1'b0; kill = 1'b0;
    endtask

    task automatic test_kill;
        logic [31:0] prev;
        logic [31:0] r;
        int          lat;
        logic        b1;
        int          seen;
        @(negedge clk);
        prev = result;
        alu_function = ALU_DIVU; in1 = 32'd50; in2 = 32'd5; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        kill = 1'b1;
        @(posedge clk);
        @(negedge clk);
        kill = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL kill_abort busy=%b done=%b want 0 0", busy, done);
        end
        checks++;
        if (result !== prev) begin errors++; $display("FAIL kill_result got %h want %h", result, prev); end
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL kill_no_done got %0d pulses want 0", seen); end
        do_op(ALU_DIVU, 32'd9, 32'd3, r, lat, b1);
        checks++;
        if (r !== 32'd3) begin errors++; $display("FAIL divu_after_kill got %h want 00000003", r); end
    endtask

    task automatic test_busy_start_and_reset;
        int lat;
        @(negedge clk);
        alu_function = ALU_DIVU; in1 = 32'd100; in2 = 32'd7; start = 1'b1;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 3) begin in1 = 32'd1000; in2 = 32'd3; end
            if (done) begin
                lat = n;
                checks++;
                if (result !== 32'd14) begin
                    errors++; $display("FAIL start_held_result got %h want 0000000e", result);
                end
                start = 1'b0;
                break;
            end
        end
        start = 1'b0;
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL start_held_latency got %0d want 33", lat); end
        @(negedge clk);
        alu_function = ALU_DIVU; in1 = 32'd100; in2 = 32'd7; start = 1'b1;
        repeat (15) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            errors++; $display("FAIL reset_mid_calc busy=%b done=%b result=%h want 0 0 0", busy, done, result);
        end
        reset = 1'b0; start = 1'b0;
    endtask

    initial begin
        test_reset;
        test_unsigned;
        test_signed;
        test_special;
        test_ignored_starts;
        test_kill;
        test_busy_start_and_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_iter_divider.md
Name: ex_iter_divider

Overview:
- Multi-cycle divide/remainder unit in the execute stage, alongside the combinational ALU.
- Takes the same ID/EX operands and 5-bit ALU function code as the ALU, and computes the RV32M DIV/DIVU/REM/REMU ops by radix-2 restoring division.
- The hazard unit stalls the front end while busy=1.
- The EX result mux selects result when done=1.

Parameters:
- XLEN, 32, operand/result width; only 32 supported.
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- alu_function  input  5  ALU_DIV/ALU_DIVU/ALU_REM/ALU_REMU codes from the shared DEFS package.
- in1  input  32  dividend (rs1).
- in2  input  32  divisor (rs2).
- kill  input  1  flush from branch/trap; aborts the op in flight.
- busy  output  1  high from the cycle after accept until done is deasserted.
- done  output  1  one-cycle pulse; result is valid.
- result  output  32  quotient or remainder; held until the next accept.

Behaviour:
- Reset, synchronous, active-high, wins over every other input: state=IDLE, busy=0, done=0, result=0, counter=0.
- Reset mid-operation discards the op; no done is produced.
- Clock and reset are fixed: one clock, clk; reset is synchronous and active-high, named reset.
- States are IDLE, CALC, DONE.
- IDLE: start=1 with a non-divide alu_function is ignored. Otherwise, latch op, signedness and operands:
  - Special case → DONE.
  - Else → CALC with counter=0.
- Signed ops (DIV, REM): divide the absolute values.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Unsigned ops (DIVU, REMU): operands are used as-is.
- Special cases resolved without iterating (result valid 1 cycle after accept):
  - in2=0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → in1.
  - Signed overflow, in1=0x80000000 and in2=0xFFFFFFFF: DIV → 0x80000000; REM → 0.
- CALC: one quotient bit per cycle, MSB first.
  - Each cycle: partial remainder R = {R[31:0], dividend MSB}; if R >= divisor, subtract and set the quotient bit to 1.
  - R is 33 bits wide so no carry is lost.
  - counter increments each cycle; after the iteration with counter=31 → DONE.
- DONE: done=1 and result is driven for exactly one cycle, then → IDLE.
  - busy=1 in CALC and DONE; busy=0 in IDLE.
  - The ALU code sets `busy = (state != IDLE)`.
- Latency:
  - Normal ops: accept at edge N, 32 CALC edges, done high during the cycle after edge N+33.
  - Special cases: done high after edge N+1.
- start while busy=1 is ignored; no queueing.
- A new start on the same cycle done=1 is ignored; it is accepted on the next IDLE cycle.
- kill=1 in CALC or DONE → IDLE next edge, done=0 that cycle; result keeps its old value.
  - kill in IDLE has no effect.
  - kill and start together in IDLE: start is ignored.
- Operands are latched at accept; in1/in2 changes during CALC have no effect.

Decomposition:
- Shared DEFS package holds:
  - the ALU_DIV/ALU_DIVU/ALU_REM/ALU_REMU codes;
  - the div_state_t enum (IDLE, CALC, DONE);
  - constants DIV_BY_ZERO_Q = 32'hFFFFFFFF and INT_MIN = 32'h80000000.
- One sub-module is natural: div_unsigned_core.
  - 32-cycle shift/subtract datapath and counter.
  - Unsigned operands in, quotient and remainder out.
- ex_iter_divider wraps it with the FSM, sign fix-up, special cases and the handshake.

Test Plan:
- DIVU 100/7, start for 1 cycle → busy high, done pulses exactly 33 cycles after accept, result=14; REMU same operands → 2.
- DIV −7 (0xFFFFFFF9) / 2 → result 0xFFFFFFFD (−3); REM same operands → 0xFFFFFFFF (−1); REM 7 / −2 → 1.
- Divide by zero: DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; done pulses 1 cycle after accept.
- Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0; both in 1 cycle.
- kill at cycle 10 of CALC → no done, busy=0 next cycle; a new DIVU 9/3 then → 3.
- reset asserted mid-CALC → busy=0, done=0, result=0 next edge; start held during busy is ignored.
